// File: rtl/systolic_result_drain.sv
// Snapshots the systolic result matrix on a completion edge and streams it
// out one element per beat, row-major, over a valid/ready handshake.
module systolic_result_drain #(
  parameter  int PE_ROW = 4,
  parameter  int PE_COL = 4,
  parameter  int DWIDTH = 32,
  parameter  int CNT_W  = 16,
  localparam int N      = PE_ROW * PE_COL,
  localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*DWIDTH-1:0] result_in,
  input  logic                final_is_finish,
  output logic [DWIDTH-1:0]   m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  output logic [IW-1:0]       m_index,
  output logic                busy,
  output logic                overrun,
  output logic [CNT_W-1:0]    done_cnt
);

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_DRAIN = 1'b1;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic                r_state;
  logic                r_finQ;
  logic [N*DWIDTH-1:0] r_snap;
  logic [IW-1:0]       r_idx;
  logic                r_overrun;
  logic [CNT_W-1:0]    r_doneCnt;

  logic                w_edge;
  logic                w_valid;
  logic                w_xfer;
  logic                w_atLast;
  logic                w_lastXfer;
  logic [DWIDTH-1:0]   w_elem;

  assign w_edge     = final_is_finish & ~r_finQ;
  assign w_valid    = (r_state == S_DRAIN);
  assign w_xfer     = w_valid & m_ready;
  assign w_atLast   = (r_idx == LAST_IDX);
  assign w_lastXfer = w_xfer & w_atLast;

  // Element 0 sits in the MSBs of the packed snapshot.
  always_comb begin
    w_elem = '0;
    for (int k = 0; k < N; k++) begin
      if (r_idx == IW'(k)) begin
        w_elem = r_snap[(N-1-k)*DWIDTH +: DWIDTH];
      end
    end
  end

  assign m_valid  = w_valid;
  assign m_data   = w_valid ? w_elem : '0;
  assign m_index  = r_idx;
  assign m_last   = w_valid & w_atLast;
  assign busy     = w_valid;
  assign overrun  = r_overrun;
  assign done_cnt = r_doneCnt;

  // An edge is taken when idle or exactly on the final transfer; any other
  // edge during a drain is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_finQ    <= 1'b0;
      r_snap    <= '0;
      r_idx     <= '0;
      r_overrun <= 1'b0;
      r_doneCnt <= '0;
    end else begin
      r_finQ <= final_is_finish;
      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            r_snap  <= result_in;
            r_idx   <= '0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_edge && !w_lastXfer) begin
            r_overrun <= 1'b1;
          end
          if (w_xfer) begin
            if (w_atLast) begin
              r_doneCnt <= r_doneCnt + CNT_W'(1);
              r_idx     <= '0;
              if (w_edge) begin
                r_snap <= result_in;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Downstream stage of the systolic subsystem. When the array signals completion, it snapshots the full packed result matrix. It then serialises the matrix one element per beat over a valid/ready stream toward the coprocessor writeback path. Because of the snapshot, the array can begin the next computation while the previous result is still draining.

## Interface

Parameters:
- PE_ROW, default 4, rows of the result matrix (must match the subsystem).
- PE_COL, default 4, columns of the result matrix.
- DWIDTH, default 32, bits per element.
- CNT_W, default 16, width of the drained-matrix counter.

Ports (N = PE_ROW*PE_COL; IW = max(1, ceil(log2 N))):
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- result_in  in  N*DWIDTH  packed result from the subsystem; element (r,c) at bits [(N-(r*PE_COL+c))*DWIDTH-1 -: DWIDTH] (element (0,0) in the MSBs).
- final_is_finish  in  1  completion flag from the subsystem; a pulse or a level, and only its rising edge is used.
- m_data  out  DWIDTH  current element.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  consumer accepts the beat.
- m_last  out  1  current beat is element N-1.
- m_index  out  IW  row-major index of the current element.
- busy  out  1  high in the DRAIN state.
- overrun  out  1  sticky; a completion edge arrived while a drain could not accept it.
- done_cnt  out  CNT_W  number of fully drained matrices, wraps modulo 2^CNT_W.

## Operation

- Edge detect:
  - fin_q <= final_is_finish every cycle.
  - edge = final_is_finish & ~fin_q.
  - fin_q resets to 0, so a level already high when reset deasserts counts as one edge.
- Transfer condition: xfer = m_valid & m_ready.
- State IDLE:
  - m_valid = 0.
  - On edge: snap <= result_in, idx <= 0, go to DRAIN.
- State DRAIN:
  - m_valid = 1.
  - m_data = snap element idx.
  - m_index = idx.
  - m_last = (idx == N-1).
- In DRAIN, on xfer with idx < N-1: idx <= idx+1.
- In DRAIN, on xfer with idx == N-1 (last beat):
  - done_cnt <= done_cnt+1.
  - If edge in the same cycle: snap <= result_in, idx <= 0, stay in DRAIN (back-to-back, no bubble).
  - Otherwise go to IDLE.
- Overrun: edge in DRAIN that is not coincident with the last beat sets overrun <= 1. That edge is discarded; snap and idx are unchanged.
- Stream rules:
  - While m_valid & ~m_ready, m_data, m_index and m_last hold stable.
  - m_valid never drops without a transfer, except on rst.
- No combinational path from m_ready to m_valid.
- Ordering is row-major, in the same element order as the subsystem's packing.
- Widths:
  - idx is IW bits and never exceeds N-1.
  - done_cnt wraps from 2^CNT_W-1 to 0.

## Timing

- Reset values: m_valid 0, m_last 0, m_data 0, m_index 0, busy 0, overrun 0, done_cnt 0, state IDLE, snap 0, fin_q 0.
- Reset mid-drain: the next cycle is IDLE with all outputs at reset values; the partial matrix is lost and done_cnt is not incremented.
- Latency:
  - edge sampled at rising edge T; first beat valid in cycle T+1.
  - With m_ready held high, N beats occupy cycles T+1 to T+N; busy falls after T+N.
- Throughput: one element per cycle at full ready; one matrix per N cycles with back-to-back edges.
- done_cnt updates in the cycle after the last xfer.
- overrun is visible in the cycle after the offending edge and clears only on rst.
- result_in needs to be valid only in the edge cycle; later changes do not affect the snapshot.

## Test plan

Directed scenarios use PE_ROW=PE_COL=2, DWIDTH=8:
- Basic drain:
  - Stimulus: result_in=32'h11223344, one-cycle final_is_finish, m_ready=1.
  - Response: beats 11,22,33,44 on 4 consecutive cycles starting the cycle after the edge; m_index 0..3; m_last only on 44; done_cnt=1; busy then low.
- Backpressure:
  - Stimulus: m_ready toggles 1,0,0,1,…
  - Response: each beat held stable through its stall cycles; order unchanged; exactly 4 transfers.
- Level-held finish and input change:
  - Stimulus: final_is_finish held high for 10 cycles; result_in changed to 32'hAABBCCDD after the edge.
  - Response: only one drain, of the 11223344 snapshot; overrun stays 0.
- Back-to-back and overrun:
  - Stimulus: second edge (result_in=32'h55667788) coincident with the last beat; later a third edge mid-drain.
  - Response: 55,66,77,88 follow 44 with no bubble; the mid-drain edge sets overrun=1, is dropped, and the current sequence is uncorrupted.
- Reset mid-drain:
  - Stimulus: rst asserted after 2 beats, then released with a new edge.
  - Response: all outputs at reset values the cycle after rst; done_cnt=0; the new drain starts from index 0.
- Counter wrap:
  - Stimulus: CNT_W=2, five complete drains.
  - Response: done_cnt sequence 1,2,3,0,1.
